m_bcd_updown_chain: RTL and testbench

M_BCD_UPDOWN_CHAIN -- requirements
Module: m_bcd_updown_chain

---
 rtl/m_bcd_updown_chain.sv | 164 ++++++++++++++++
 tb/tb_m_bcd_updown_chain.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/m_bcd_updown_chain.sv
// m_bcd_updown_chain
//   Multi-digit BCD up/down counter. Each digit has its own maximum, so the
//   chain can count in mixed radix, for example mm:ss with DIG_MAX = 16'h5959.
//   A small IDLE/RUN/DONE FSM gates the count.
//
//   Input priority each cycle is load > stop > start > tick.
//   Carry and borrow ripple through every digit within a single cycle.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   tick      count strobe; one step per cycle while high in RUN
//   mode      0 = count up, 1 = count down
//   load      synchronous load of load_val (each digit clamped to its max)
//   load_val  BCD value to load
//   start     request to run (from IDLE or DONE)
//   stop      request to pause (RUN -> IDLE)
//   cnt_out   registered BCD count
//   running   high while in RUN
//   done      registered one-cycle terminal pulse
//   zero      combinational, high when cnt_out == 0
//
// State | Meaning
//   S_IDLE | stopped; count held; waiting for start
//   S_RUN  | counting on qualifying ticks
//   S_DONE | terminal value reached; count held; ticks ignored
module m_bcd_updown_chain #(
  parameter int                  NDIG    = 4,
  parameter logic [4*NDIG-1:0]   DIG_MAX = 16'h5959,
  parameter int                  WRAP    = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                mode,
  input  logic                load,
  input  logic [4*NDIG-1:0]   load_val,
  input  logic                start,
  input  logic                stop,
  output logic [4*NDIG-1:0]   cnt_out,
  output logic                running,
  output logic                done,
  output logic                zero
);

  localparam int W = 4 * NDIG;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           done_q, done_d;

  logic [W-1:0]   inc_val, dec_val, clamp_val;
  logic           is_zero, all_max;

  assign is_zero = (cnt_q == '0);
  assign all_max = (cnt_q == DIG_MAX);

  // Ripple increment, decrement and load clamp, one digit at a time.
  // A digit at or above its maximum rolls to 0 on increment; this also
  // keeps the chain sane if a digit were ever out of range.
  always_comb begin
    logic carry, borrow;
    inc_val   = cnt_q;
    dec_val   = cnt_q;
    clamp_val = load_val;
    carry     = 1'b1;
    borrow    = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (carry) begin
        if (cnt_q[4*i +: 4] >= DIG_MAX[4*i +: 4]) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (cnt_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = DIG_MAX[4*i +: 4];
        end else begin
          dec_val[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
      // Non-BCD nibbles (A..F) are above any legal max, so they clamp too.
      if (load_val[4*i +: 4] > DIG_MAX[4*i +: 4]) begin
        clamp_val[4*i +: 4] = DIG_MAX[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (load) begin
      cnt_d   = clamp_val;
      state_d = S_IDLE;
    end else if (stop) begin
      if (state_q == S_RUN) begin
        state_d = S_IDLE;
      end
    end else if (start) begin
      if (state_q != S_RUN) begin
        // Down-counting from zero has nothing to do.
        state_d = (mode && is_zero) ? S_IDLE : S_RUN;
      end
    end else if (tick && (state_q == S_RUN)) begin
      if (!mode) begin
        if (all_max) begin
          if (WRAP != 0) begin
            cnt_d  = '0;
            done_d = 1'b1;
          end else begin
            // Saturated: hold the count and terminate.
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = inc_val;
          if ((WRAP == 0) && (inc_val == DIG_MAX)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end else begin
        if (is_zero) begin
          // Already at zero (mode flipped while running): hold, no pulse.
          state_d = S_DONE;
        end else begin
          cnt_d = dec_val;
          if (dec_val == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign cnt_out = cnt_q;
  assign running = (state_q == S_RUN);
  assign done    = done_q;
  assign zero    = is_zero;

endmodule

// File: tb/tb_m_bcd_updown_chain.sv
// tb_m_bcd_updown_chain
//   Directed bench for m_bcd_updown_chain with NDIG=4, DIG_MAX=16'h5959.
//   Two instances share stimulus: dut (WRAP=0) and dut_w (WRAP=1).
//   Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_m_bcd_updown_chain;

  logic        clk;
  logic        reset;
  logic        tick, mode, load, start, stop;
  logic [15:0] load_val;
  logic [15:0] cnt_out, cnt_out_w;
  logic        running, done, zero;
  logic        running_w, done_w, zero_w;

  int total = 0;
  int bad   = 0;

  m_bcd_updown_chain #(.NDIG(4), .DIG_MAX(16'h5959), .WRAP(0)) dut (
    .clk(clk), .reset(reset), .tick(tick), .mode(mode), .load(load),
    .load_val(load_val), .start(start), .stop(stop),
    .cnt_out(cnt_out), .running(running), .done(done), .zero(zero)
  );

  m_bcd_updown_chain #(.NDIG(4), .DIG_MAX(16'h5959), .WRAP(1)) dut_w (
    .clk(clk), .reset(reset), .tick(tick), .mode(mode), .load(load),
    .load_val(load_val), .start(start), .stop(stop),
    .cnt_out(cnt_out_w), .running(running_w), .done(done_w), .zero(zero_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of request inputs, then sample 1 ns after the edge.
  task automatic cyc(input logic ld, input logic [15:0] lv,
                     input logic st, input logic sp, input logic tk);
    load = ld; load_val = lv; start = st; stop = sp; tick = tk;
    @(posedge clk);
    #1;
    load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
  endtask

  // Mixed-radix value (digits radix 10,6,10,6) to BCD for the down-count walk.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 6);
    r[11:8]  = 4'((v / 60) % 10);
    r[15:12] = 4'((v / 600) % 6);
    return r;
  endfunction

  initial begin
    reset = 1'b1; tick = 1'b0; mode = 1'b0; load = 1'b0;
    start = 1'b0; stop = 1'b0; load_val = '0;
    #12;
    chk("rst_cnt",     cnt_out, 32'h0);
    chk("rst_running", running, 0);
    chk("rst_done",    done,    0);
    chk("rst_zero",    zero,    1);
    reset = 1'b0;

    // Down count 0x0102 (=62 steps) to zero.
    mode = 1'b1;
    cyc(1, 16'h0102, 0, 0, 0);
    chk("a_load", cnt_out, 32'h0102);
    chk("a_idle", running, 0);
    cyc(0, 0, 1, 0, 0);
    chk("a_run", running, 1);
    for (int i = 1; i <= 62; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk("a_step", cnt_out, 32'(to_bcd(62 - i)));
      if (i == 1)  chk("a_first", cnt_out, 32'h0101);
      if (i == 61) chk("a_nodone", done, 0);
    end
    chk("a_done",    done,    1);
    chk("a_zero",    zero,    1);
    chk("a_running", running, 0);
    cyc(0, 0, 0, 0, 1);
    chk("a_done_1cyc", done,    0);
    chk("a_hold",      cnt_out, 32'h0000);

    // Full borrow ripple.
    cyc(1, 16'h1000, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("b_ripple", cnt_out, 32'h0959);

    // Up count to all-max: saturate (WRAP=0) vs wrap (WRAP=1).
    mode = 1'b0;
    cyc(1, 16'h5958, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("c_max",       cnt_out,   32'h5959);
    chk("c_done",      done,      1);
    chk("c_stopped",   running,   0);
    chk("cw_max",      cnt_out_w, 32'h5959);
    chk("cw_nodone",   done_w,    0);
    chk("cw_running",  running_w, 1);
    cyc(0, 0, 0, 0, 1);
    chk("c_ignored",   cnt_out,   32'h5959);
    chk("c_done_1cyc", done,      0);
    chk("cw_wrap",     cnt_out_w, 32'h0000);
    chk("cw_done",     done_w,    1);
    chk("cw_run_keep", running_w, 1);

    // Load wins over start and tick; out-of-range digits clamp.
    cyc(1, 16'h7A99, 1, 0, 1);
    chk("d_clamp",   cnt_out, 32'h5959);
    chk("d_idle",    running, 0);
    chk("d_nodone",  done,    0);

    // Start in down mode at zero stays idle.
    mode = 1'b1;
    cyc(1, 16'h0000, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("e_idle",   running, 0);
    chk("e_nodone", done,    0);

    // Stop pauses with count held; mode change then counts up.
    cyc(1, 16'h0005, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("s_dec", cnt_out, 32'h0004);
    cyc(0, 0, 0, 1, 0);
    chk("s_idle", running, 0);
    cyc(0, 0, 0, 0, 1);
    chk("s_held", cnt_out, 32'h0004);
    mode = 1'b0;
    cyc(0, 0, 1, 0, 0);
    chk("s_modechg_hold", cnt_out, 32'h0004);
    cyc(0, 0, 0, 0, 1);
    chk("s_up", cnt_out, 32'h0005);

    // Asynchronous reset mid-run.
    cyc(1, 16'h0230, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("f_run", running, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("f_async_cnt", cnt_out, 32'h0000);
    chk("f_async_run", running, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(0, 0, 0, 0, 1);
    chk("f_tick_ign", cnt_out, 32'h0000);
    chk("f_still_idle", running, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("f_restart", cnt_out, 32'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
